// File: rtl/mips_bus_lsu_pkg.sv
// mips_bus_lsu_pkg: shared CPU memory-op, error and LSU state types.
// Also holds small op-classification helpers used by the LSU.
package mips_bus_lsu_pkg;

  typedef enum logic [2:0] {
    OP_LB, OP_LBU, OP_LH, OP_LHU,
    OP_LW, OP_SB, OP_SH, OP_SW
  } mem_op_t;

  typedef enum logic [1:0] {
    ERR_NONE, ERR_ALIGN, ERR_TIMEOUT
  } err_t;

  typedef enum logic [1:0] {
    S_IDLE, S_BUS, S_RESP
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B, SZ_H, SZ_W
  } mem_size_t;

  localparam int LSU_TIMEOUT_DEFAULT = 255;

  function automatic mem_size_t op_size(mem_op_t op);
    mem_size_t sz;
    unique case (op)
      OP_LB, OP_LBU, OP_SB: sz = SZ_B;
      OP_LH, OP_LHU, OP_SH: sz = SZ_H;
      default:              sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic op_is_load(mem_op_t op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
  endfunction

  function automatic logic op_signed(mem_op_t op);
    return op inside {OP_LB, OP_LH};
  endfunction

  function automatic logic misaligned(mem_op_t op, logic [1:0] a);
    logic bad;
    unique case (op_size(op))
      SZ_H:    bad = a[0];
      SZ_W:    bad = |a;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mips_bus_lsu_lane.sv
// mips_lsu_lane: lane select, byteenable, store replication and
// load extraction/extension for a DATA_W-wide Avalon data bus.
module mips_lsu_lane
  import mips_bus_lsu_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int OW     = $clog2(NB)
) (
  input  mem_op_t           op,
  input  logic [OW-1:0]     off,
  input  logic [31:0]       wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] wdata_rep,
  output logic [31:0]       rdata_ext
);

  mem_size_t     sz;
  logic [NB-1:0] base;
  logic [31:0]   sh;
  logic          sgn;

  assign sz  = op_size(op);
  assign sgn = op_signed(op);
  assign be  = base << off;

  // Decode access width into lane mask, replicated data and extended load.
  always_comb begin
    base      = '0;
    wdata_rep = '0;
    rdata_ext = '0;
    sh        = 32'(bus_rdata >> {off, 3'b000});
    unique case (1'b1)
      sz == SZ_B: begin
        base      = NB'(1);
        wdata_rep = {NB{wdata[7:0]}};
        rdata_ext = {{24{sgn & sh[7]}}, sh[7:0]};
      end
      sz == SZ_H: begin
        base      = NB'(3);
        wdata_rep = {(NB/2){wdata[15:0]}};
        rdata_ext = {{16{sgn & sh[15]}}, sh[15:0]};
      end
      default: begin
        base      = NB'(15);
        wdata_rep = {(NB/4){wdata}};
        rdata_ext = sh;
      end
    endcase
  end

endmodule

// File: rtl/mips_bus_lsu.sv
// mips_bus_lsu: CPU load/store unit driving an Avalon-MM master port.
// IDLE/BUS/RESP FSM with alignment check and waitrequest timeout.
module mips_bus_lsu
  import mips_bus_lsu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  mem_op_t             req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [31:0]         req_wdata,
  output logic                resp_valid,
  output logic [31:0]         resp_rdata,
  output err_t                resp_err,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  input  logic                waitrequest,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   readdata
);

  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam logic [15:0] TO = 16'(TIMEOUT);

  lsu_state_t        state_q, state_d;
  mem_op_t           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  err_t              err_q, err_d;
  logic [NB-1:0]     lane_be;
  logic [DATA_W-1:0] lane_wd;
  logic [31:0]       lane_rd;
  logic              in_bus;
  logic              is_ld;

  mips_lsu_lane #(.DATA_W(DATA_W)) u_lane (
    .op       (op_q),
    .off      (addr_q[OW-1:0]),
    .wdata    (wdata_q),
    .bus_rdata(readdata),
    .be       (lane_be),
    .wdata_rep(lane_wd),
    .rdata_ext(lane_rd)
  );

  assign in_bus     = state_q == S_BUS;
  assign is_ld      = op_is_load(op_q);
  assign req_ready  = state_q == S_IDLE;
  assign resp_valid = state_q == S_RESP;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign read       = in_bus & is_ld;
  assign write      = in_bus & ~is_ld;
  assign byteenable = in_bus ? lane_be : '0;
  assign writedata  = lane_wd;
  assign address    = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};

  // Next-state, request latch, stall counter and response capture.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = '0;
          if (misaligned(req_op, req_addr[1:0])) begin
            state_d = S_RESP;
            err_d   = ERR_ALIGN;
            rdata_d = '0;
          end else begin
            state_d = S_BUS;
          end
        end
      end
      S_BUS: begin
        if (!waitrequest) begin
          state_d = S_RESP;
          err_d   = ERR_NONE;
          rdata_d = is_ld ? lane_rd : '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == TO) begin
            state_d = S_RESP;
            err_d   = ERR_TIMEOUT;
            rdata_d = '0;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_LB;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mips_bus_lsu.sv
// tb_mips_bus_lsu: vector table, hand sequences and random traffic
// against a 32-bit (TIMEOUT=4) and a 64-bit LSU instance.
module tb_mips_bus_lsu;
  import mips_bus_lsu_pkg::*;

  localparam int TMO_A = 4;
  localparam int TMO_B = 255;

  logic clk = 0;
  always #5 clk = ~clk;

  logic        reset;
  logic        sel;
  logic        req_valid;
  mem_op_t     req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        waitrequest;
  logic [63:0] readdata;

  logic        a_ready, a_rv, a_rd, a_wr;
  logic [31:0] a_rdata, a_addr, a_wd;
  err_t        a_err;
  logic [3:0]  a_be;
  logic        b_ready, b_rv, b_rd, b_wr;
  logic [31:0] b_rdata, b_addr;
  logic [63:0] b_wd;
  err_t        b_err;
  logic [7:0]  b_be;

  mips_bus_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TMO_A)) u_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & ~sel), .req_ready(a_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(a_rv), .resp_rdata(a_rdata), .resp_err(a_err),
    .address(a_addr), .read(a_rd), .write(a_wr),
    .waitrequest(waitrequest), .writedata(a_wd),
    .byteenable(a_be), .readdata(readdata[31:0])
  );

  mips_bus_lsu #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TMO_B)) u_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & sel), .req_ready(b_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(b_rv), .resp_rdata(b_rdata), .resp_err(b_err),
    .address(b_addr), .read(b_rd), .write(b_wr),
    .waitrequest(waitrequest), .writedata(b_wd),
    .byteenable(b_be), .readdata(readdata)
  );

  wire        o_ready = sel ? b_ready : a_ready;
  wire        o_rv    = sel ? b_rv : a_rv;
  wire        o_read  = sel ? b_rd : a_rd;
  wire        o_write = sel ? b_wr : a_wr;
  wire [31:0] o_rdata = sel ? b_rdata : a_rdata;
  wire [1:0]  o_err   = sel ? b_err : a_err;
  wire [31:0] o_addr  = sel ? b_addr : a_addr;
  wire [63:0] o_wd    = sel ? b_wd : {32'b0, a_wd};
  wire [7:0]  o_be    = sel ? b_be : {4'b0, a_be};

  typedef struct {
    int          lat;
    int          strb;
    logic [7:0]  be;
    logic [31:0] addr;
    logic [63:0] wd;
    logic [31:0] rdata;
    err_t        err;
  } exp_t;

  typedef struct {
    int          lat;
    int          strb;
    int          wr;
    bit          bad;
    logic [7:0]  be;
    logic [31:0] addr;
    logic [63:0] wd;
    logic [31:0] rdata;
    logic [1:0]  err;
    bit          ready_after;
    bit          valid_after;
    bit          hold;
  } res_t;

  typedef struct {
    bit          s;
    mem_op_t     op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [63:0] rd;
    int          stall;
    exp_t        e;
  } vec_t;

  vec_t tbl[$];
  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic bit is_load(mem_op_t op);
    return op == OP_LB || op == OP_LBU || op == OP_LH ||
           op == OP_LHU || op == OP_LW;
  endfunction

  function automatic void add(bit s, mem_op_t op, logic [31:0] a,
      logic [31:0] wd, logic [63:0] rd, int st, int lat, int strb,
      logic [7:0] be, logic [31:0] ea, logic [63:0] ewd,
      logic [31:0] erd, err_t err);
    vec_t v;
    v.s = s; v.op = op; v.addr = a; v.wdata = wd; v.rd = rd;
    v.stall = st;
    v.e.lat = lat; v.e.strb = strb; v.e.be = be; v.e.addr = ea;
    v.e.wd = ewd; v.e.rdata = erd; v.e.err = err;
    tbl.push_back(v);
  endfunction

  // Reference: derive bus and response behaviour from access size,
  // byte lane and stall count using plain arithmetic.
  function automatic exp_t model(bit s, mem_op_t op, logic [31:0] a,
      logic [31:0] wd, logic [63:0] rd, int stall);
    exp_t e;
    int nb, tmo, sz, lane;
    bit sgn;
    logic [63:0] m, v, w;
    nb   = s ? 8 : 4;
    tmo  = s ? TMO_B : TMO_A;
    sz   = (op == OP_LB || op == OP_LBU || op == OP_SB) ? 1 :
           (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 4;
    sgn  = (op == OP_LB || op == OP_LH);
    lane = int'(a % nb);
    m    = (64'd1 << (8 * sz)) - 1;
    e.be   = 8'(((1 << sz) - 1) << lane);
    e.addr = a - lane;
    w = 64'(wd) & m;
    e.wd = 0;
    for (int i = 0; i < nb / sz; i++) e.wd |= w << (8 * sz * i);
    e.rdata = 0;
    if (a % sz != 0) begin
      e.err = ERR_ALIGN; e.lat = 1; e.strb = 0;
    end else if (stall > tmo) begin
      e.err = ERR_TIMEOUT; e.lat = tmo + 2; e.strb = tmo + 1;
    end else begin
      e.err = ERR_NONE; e.lat = stall + 2; e.strb = stall + 1;
      if (is_load(op)) begin
        v = (rd >> (8 * lane)) & m;
        if (sgn && v[8*sz-1]) v |= ~m;
        e.rdata = v[31:0];
      end
    end
    return e;
  endfunction

  task automatic run(input bit s, input mem_op_t op,
      input logic [31:0] a, input logic [31:0] wd,
      input logic [63:0] rd, input int stall, output res_t r);
    int left;
    bit first;
    int k;
    left = stall; first = 1;
    r.lat = 0; r.strb = 0; r.wr = 0; r.bad = 0; r.be = 0;
    r.addr = 0; r.wd = 0; r.rdata = 0; r.err = 0;
    r.ready_after = 0; r.valid_after = 0; r.hold = 0;
    sel = s; req_op = op; req_addr = a; req_wdata = wd;
    readdata = rd; waitrequest = 0; req_valid = 1;
    #1;
    k = 0;
    while (!o_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    @(posedge clk); #1;
    req_valid = 0;
    req_op    = mem_op_t'($urandom_range(0, 7));
    req_addr  = $urandom;
    req_wdata = $urandom;
    for (k = 1; k <= 400; k++) begin
      if (o_rv) begin
        r.lat = k; r.rdata = o_rdata; r.err = o_err;
        break;
      end
      if (o_read || o_write) begin
        if (first) begin
          r.be = o_be; r.addr = o_addr; r.wd = o_wd; first = 0;
        end else if (o_be != r.be || o_addr != r.addr || o_wd != r.wd)
          r.bad = 1;
        if (o_read && o_write) r.bad = 1;
        r.strb++;
        if (o_write) r.wr++;
        waitrequest = (left > 0);
        if (left > 0) left--;
      end else begin
        waitrequest = 0;
      end
      @(posedge clk); #1;
    end
    waitrequest = 0;
    if (r.lat > 0) begin
      @(posedge clk); #1;
      r.ready_after = o_ready;
      r.valid_after = o_rv;
      r.hold = (o_rdata == r.rdata) && (o_err == r.err);
    end
  endtask

  function automatic void check_txn(string nm, mem_op_t op,
      res_t r, exp_t e);
    chk({nm, " latency"}, 64'(r.lat), 64'(e.lat));
    chk({nm, " err"}, 64'(r.err), 64'(e.err));
    chk({nm, " strobe cycles"}, 64'(r.strb), 64'(e.strb));
    if (e.strb > 0) begin
      chk({nm, " byteenable"}, 64'(r.be), 64'(e.be));
      chk({nm, " address"}, 64'(r.addr), 64'(e.addr));
      chk({nm, " writedata"}, r.wd, e.wd);
      chk({nm, " write cycles"}, 64'(r.wr),
          64'(is_load(op) ? 0 : e.strb));
      chk({nm, " bus stable"}, 64'(r.bad), 64'(0));
    end
    if (e.err != ERR_ALIGN)
      chk({nm, " rdata"}, 64'(r.rdata), 64'(e.rdata));
    chk({nm, " single resp"}, 64'(r.valid_after), 64'(0));
    chk({nm, " ready after"}, 64'(r.ready_after), 64'(1));
    chk({nm, " resp hold"}, 64'(r.hold), 64'(1));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    exp_t e;
    vec_t v;
    bit s;
    mem_op_t op;
    logic [31:0] a, wd;
    logic [63:0] rd;
    int st;

    reset = 0; sel = 0; req_valid = 0; req_op = OP_LB;
    req_addr = 0; req_wdata = 0; waitrequest = 0; readdata = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      sel = i[0];
      #1;
      chk($sformatf("reset%0d read", i), 64'(o_read), 0);
      chk($sformatf("reset%0d write", i), 64'(o_write), 0);
      chk($sformatf("reset%0d be", i), 64'(o_be), 0);
      chk($sformatf("reset%0d address", i), 64'(o_addr), 0);
      chk($sformatf("reset%0d writedata", i), o_wd, 0);
      chk($sformatf("reset%0d resp_valid", i), 64'(o_rv), 0);
      chk($sformatf("reset%0d rdata", i), 64'(o_rdata), 0);
      chk($sformatf("reset%0d err", i), 64'(o_err), 0);
      chk($sformatf("reset%0d ready", i), 64'(o_ready), 1);
    end
    sel = 0;
    reset = 1;
    @(posedge clk); #1;

    add(0, OP_LB,  32'h103, 0, 64'h80FFFFFF, 0,
        2, 1, 8'h08, 32'h100, 0, 32'hFFFFFF80, ERR_NONE);
    add(0, OP_SH,  32'h202, 32'h0000BEEF, 0, 3,
        5, 4, 8'h0C, 32'h200, 64'hBEEFBEEF, 0, ERR_NONE);
    add(0, OP_LW,  32'h101, 0, 0, 0,
        1, 0, 0, 0, 0, 0, ERR_ALIGN);
    add(0, OP_LHU, 32'h301, 0, 0, 0,
        1, 0, 0, 0, 0, 0, ERR_ALIGN);
    add(0, OP_SH,  32'h003, 32'h1234, 0, 0,
        1, 0, 0, 0, 0, 0, ERR_ALIGN);
    add(0, OP_LW,  32'h400, 0, 64'hDEADBEEF, 100,
        6, 5, 8'h0F, 32'h400, 0, 0, ERR_TIMEOUT);
    add(0, OP_LBU, 32'h001, 0, 64'h0000F100, 0,
        2, 1, 8'h02, 32'h000, 0, 32'h000000F1, ERR_NONE);
    add(0, OP_LH,  32'h002, 0, 64'h9ABC0000, 0,
        2, 1, 8'h0C, 32'h000, 0, 32'hFFFF9ABC, ERR_NONE);
    add(0, OP_SB,  32'h013, 32'h123456A5, 0, 1,
        3, 2, 8'h08, 32'h010, 64'hA5A5A5A5, 0, ERR_NONE);
    add(0, OP_SW,  32'h024, 32'hCAFEF00D, 0, 4,
        6, 5, 8'h0F, 32'h024, 64'hCAFEF00D, 0, ERR_NONE);
    add(0, OP_LW,  32'h008, 0, 64'h13572468, 0,
        2, 1, 8'h0F, 32'h008, 0, 32'h13572468, ERR_NONE);
    add(1, OP_LHU, 32'h106, 0, 64'h8001_0000_0000_0000, 0,
        2, 1, 8'hC0, 32'h100, 0, 32'h00008001, ERR_NONE);
    add(1, OP_SB,  32'h105, 32'h00000077, 0, 0,
        2, 1, 8'h20, 32'h100, 64'h7777777777777777, 0, ERR_NONE);
    add(1, OP_LW,  32'h10C, 0, 64'h89ABCDEF_01234567, 2,
        4, 3, 8'hF0, 32'h108, 0, 32'h89ABCDEF, ERR_NONE);

    foreach (tbl[i]) begin
      v = tbl[i];
      run(v.s, v.op, v.addr, v.wdata, v.rd, v.stall, r);
      check_txn($sformatf("vec%0d", i), v.op, r, v.e);
    end

    // Reset asserted mid-BUS during a stalled store.
    sel = 0; req_op = OP_SW; req_addr = 32'h40;
    req_wdata = 32'h11223344; waitrequest = 1; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    chk("midrst write on", 64'(o_write), 1);
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    chk("midrst write off", 64'(o_write), 0);
    chk("midrst be off", 64'(o_be), 0);
    chk("midrst no resp", 64'(o_rv), 0);
    chk("midrst ready", 64'(o_ready), 1);
    reset = 1;
    waitrequest = 0;
    run(0, OP_LW, 32'h44, 0, 64'h55, 100, r);
    e = model(0, OP_LW, 32'h44, 0, 64'h55, 100);
    check_txn("midrst follow", OP_LW, r, e);

    for (int n = 0; n < 150; n++) begin
      s  = 1'($urandom_range(0, 1));
      op = mem_op_t'($urandom_range(0, 7));
      a  = $urandom & 32'h0000_0FFF;
      wd = $urandom;
      rd = {$urandom, $urandom};
      st = s ? $urandom_range(0, 3) : $urandom_range(0, 6);
      run(s, op, a, wd, rd, st, r);
      e = model(s, op, a, wd, rd, st);
      check_txn($sformatf("rnd%0d", n), op, r, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
